// File: rtl/mcp4922_pkg.sv
// mcp4922_pkg
// Shared definitions for the MCP4922 SPI command frame, used by both the
// transmitter and the receiver so the two ends always agree on bit layout.
//   - Frame bit positions (A/B select, BUF, GA_n, SHDN_n, 12-bit code)
//   - Config bit order {BUF, GA_n, SHDN_n} as presented on cfg_a/cfg_b
//   - Frame length and the saturation point of the receiver bit counter
//   - Receiver FSM state type and per-channel register layout
package mcp4922_pkg;

  localparam int FRAME_LEN  = 16;
  localparam int AB_BIT     = 15;
  localparam int BUF_BIT    = 14;
  localparam int GA_N_BIT   = 13;
  localparam int SHDN_N_BIT = 12;
  localparam int CODE_MSB   = 11;
  localparam int CODE_W     = 12;

  // Index of each config bit inside the 3-bit cfg vector.
  localparam int CFG_W      = 3;
  localparam int CFG_BUF    = 2;
  localparam int CFG_GA_N   = 1;
  localparam int CFG_SHDN_N = 0;

  // The counter must be able to tell "exactly 16" from "more than 16",
  // so it stops at 17 instead of wrapping back onto 16.
  localparam int CNT_W   = 5;
  localparam int CNT_SAT = FRAME_LEN + 1;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_COMMIT
  } rx_state_t;

  // One DAC channel worth of latched state: config bits plus code.
  typedef struct packed {
    logic [CFG_W-1:0]  cfg;
    logic [CODE_W-1:0] code;
  } chan_reg_t;

  function automatic logic [CFG_W-1:0] frame_cfg(input logic [FRAME_LEN-1:0] f);
    logic [CFG_W-1:0] c;
    c             = '0;
    c[CFG_BUF]    = f[BUF_BIT];
    c[CFG_GA_N]   = f[GA_N_BIT];
    c[CFG_SHDN_N] = f[SHDN_N_BIT];
    return c;
  endfunction

  function automatic logic [CODE_W-1:0] frame_code(input logic [FRAME_LEN-1:0] f);
    return f[CODE_MSB:0];
  endfunction

endpackage

// File: rtl/mcp4922_rx_spi_pin_sync.sv
// spi_pin_sync
// Brings one asynchronous pin into the clk domain through a SYNC_STAGES
// flop chain, then compares against one more flop to find edges.
// Ports:
//   clk, reset_n : system clock, async active-low reset
//   pin          : raw asynchronous input
//   level        : synchronized level
//   rise, fall   : single-cycle edge strobes on the synchronized level
// RESET_VAL is the idle level of the pin, so leaving reset does not
// fabricate an edge.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Plain shift chain; written as a loop so a single stage also works.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/mcp4922_rx.sv
// mcp4922_rx
// Receiving end of the MCP4922 DAC link: deserializes 16-bit SPI command
// frames, keeps per-channel input registers, and models LDAC double
// buffering into the output registers.
// Ports:
//   clk, reset_n         : system clock, async active-low reset
//   cs_pin               : SPI chip select (active low, asynchronous)
//   clk_pin, data_pin    : SPI clock (sampled on rise) and data, MSB first
//   ldac_n               : latch-DAC, active low
//   out_a, out_b         : channel codes, forced to 0 while shut down
//   cfg_a, cfg_b         : latched {BUF, GA_n, SHDN_n} per channel
//   word_valid           : pulse when a 16-bit frame is accepted
//   word_axis            : A/B bit of the last accepted frame
//   frame_err            : pulse when a frame had the wrong bit count
module mcp4922_rx
  import mcp4922_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BITS        = 12
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cs_pin,
  input  logic            clk_pin,
  input  logic            data_pin,
  input  logic            ldac_n,
  output logic [BITS-1:0] out_a,
  output logic [BITS-1:0] out_b,
  output logic [2:0]      cfg_a,
  output logic [2:0]      cfg_b,
  output logic            word_valid,
  output logic            word_axis,
  output logic            frame_err
);

  logic cs_level, cs_rise, cs_fall;
  logic clk_level, clk_rise, clk_fall;
  logic data_level, data_rise, data_fall;
  logic ldac_level, ldac_rise, ldac_fall;

  // All four chains have the same depth so data stays aligned with the
  // SPI clock edge that samples it.
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset_n(reset_n), .pin(cs_pin),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_clk_sync (
    .clk(clk), .reset_n(reset_n), .pin(clk_pin),
    .level(clk_level), .rise(clk_rise), .fall(clk_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_data_sync (
    .clk(clk), .reset_n(reset_n), .pin(data_pin),
    .level(data_level), .rise(data_rise), .fall(data_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ldac_sync (
    .clk(clk), .reset_n(reset_n), .pin(ldac_n),
    .level(ldac_level), .rise(ldac_rise), .fall(ldac_fall)
  );

  // Edge strobes this block has no use for.
  logic unused_sync;
  assign unused_sync = ^{cs_level, clk_level, clk_fall, data_rise, data_fall,
                         ldac_rise, ldac_fall};

  rx_state_t            state;
  logic [FRAME_LEN-1:0] sreg;
  logic [CNT_W-1:0]     cnt;
  chan_reg_t            in_reg_a, in_reg_b;
  chan_reg_t            out_reg_a, out_reg_b;

  // Frame FSM. A cs rising edge wins over a simultaneous SPI clock edge,
  // so a late clock at the end of a frame is dropped rather than counted.
  // Input registers only change in COMMIT, and only for a full 16-bit frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RX_IDLE;
      sreg       <= '0;
      cnt        <= '0;
      in_reg_a   <= '0;
      in_reg_b   <= '0;
      word_valid <= 1'b0;
      word_axis  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (cs_fall) begin
            state <= RX_SHIFT;
            sreg  <= '0;
            cnt   <= '0;
          end
        end
        RX_SHIFT: begin
          if (cs_rise) begin
            state <= RX_COMMIT;
          end else if (clk_rise) begin
            sreg <= {sreg[FRAME_LEN-2:0], data_level};
            if (cnt != CNT_W'(CNT_SAT)) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RX_COMMIT: begin
          state <= RX_IDLE;
          if (cnt == CNT_W'(FRAME_LEN)) begin
            word_valid <= 1'b1;
            word_axis  <= sreg[AB_BIT];
            if (sreg[AB_BIT]) begin
              in_reg_b <= '{cfg: frame_cfg(sreg), code: frame_code(sreg)};
            end else begin
              in_reg_a <= '{cfg: frame_cfg(sreg), code: frame_code(sreg)};
            end
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // LDAC double buffer: while ldac is low the outputs track the input
  // registers, so the falling edge moves both channels in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg_a <= '0;
      out_reg_b <= '0;
    end else if (!ldac_level) begin
      out_reg_a <= in_reg_a;
      out_reg_b <= in_reg_b;
    end
  end

  // A shut-down channel drives 0, but its config bits remain visible.
  assign out_a = out_reg_a.cfg[CFG_SHDN_N] ? BITS'(out_reg_a.code) : '0;
  assign out_b = out_reg_b.cfg[CFG_SHDN_N] ? BITS'(out_reg_b.code) : '0;
  assign cfg_a = out_reg_a.cfg;
  assign cfg_b = out_reg_b.cfg;

endmodule
